// File: rtl/camera_capture_ctrl_if.sv
// Pixel-stream bundle for the capture sequencer: sensor/RGB input side and
// cropped output side. The controller uses the slave view.
interface camera_capture_ctrl_if;
    logic        CAMERA_FVAL;
    logic [11:0] RGB_R;
    logic [11:0] RGB_G;
    logic [11:0] RGB_B;
    logic [11:0] RGB_X;
    logic [11:0] RGB_Y;
    logic        RGB_VALID;

    logic [11:0] OUT_R;
    logic [11:0] OUT_G;
    logic [11:0] OUT_B;
    logic        OUT_VALID;
    logic        OUT_SOP;
    logic        OUT_EOP;

    modport master (
        output CAMERA_FVAL, RGB_R, RGB_G, RGB_B, RGB_X, RGB_Y, RGB_VALID,
        input  OUT_R, OUT_G, OUT_B, OUT_VALID, OUT_SOP, OUT_EOP
    );

    modport slave (
        input  CAMERA_FVAL, RGB_R, RGB_G, RGB_B, RGB_X, RGB_Y, RGB_VALID,
        output OUT_R, OUT_G, OUT_B, OUT_VALID, OUT_SOP, OUT_EOP
    );
endinterface

// File: rtl/camera_capture_ctrl.sv
// Frame-capture sequencer: arms on start, aligns to a frame boundary, decimates
// frames, crops to a latched ROI and emits a registered pixel stream with SOP/EOP.
module camera_capture_ctrl #(
    parameter int VIDEO_W = 1280,
    parameter int VIDEO_H = 720,
    parameter int CNT_W   = 16
) (
    input  logic                 CAMERA_PIXCLK,
    input  logic                 reset_n,
    camera_capture_ctrl_if.slave pix,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 continuous,
    input  logic [3:0]           skip,
    input  logic [11:0]          roi_x0,
    input  logic [11:0]          roi_x1,
    input  logic [11:0]          roi_y0,
    input  logic [11:0]          roi_y1,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic                 short_frame,
    output logic                 cfg_err
);

    localparam logic [11:0] X_MAX = 12'(VIDEO_W - 1);
    localparam logic [11:0] Y_MAX = 12'(VIDEO_H - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ARM      = 3'd1;
    localparam logic [2:0] WAIT_SOF = 3'd2;
    localparam logic [2:0] SKIP     = 3'd3;
    localparam logic [2:0] CAPTURE  = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic        fv_d;
    logic        fvr;
    logic        fvf;
    logic        stop_pend;
    logic        stop_any;
    logic [3:0]  skip_cnt;
    logic        cont_l;
    logic [11:0] lx0, lx1, ly0, ly1;
    logic [11:0] cx0, cx1, cy0, cy1;
    logic        roi_bad;
    logic        sof_take;
    logic        in_win;
    logic        pass;
    logic        is_sop;
    logic        is_eop;
    logic        done_eop;
    logic        done_short;

    // FVAL edge detection against the previous-cycle sample
    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            fv_d <= 1'b0;
        end else begin
            fv_d <= pix.CAMERA_FVAL;
        end
    end

    assign fvr = pix.CAMERA_FVAL & ~fv_d;
    assign fvf = ~pix.CAMERA_FVAL & fv_d;

    always_comb begin
        cx0 = (roi_x0 > X_MAX) ? X_MAX : roi_x0;
        cx1 = (roi_x1 > X_MAX) ? X_MAX : roi_x1;
        cy0 = (roi_y0 > Y_MAX) ? Y_MAX : roi_y0;
        cy1 = (roi_y1 > Y_MAX) ? Y_MAX : roi_y1;
    end

    assign roi_bad  = (cx0 > cx1) | (cy0 > cy1);
    assign stop_any = stop_pend | stop;
    // A stop coinciding with the frame edge in WAIT_SOF wins over the latch
    assign sof_take = (state == WAIT_SOF) & fvr & ~stop;

    assign in_win = (pix.RGB_X >= lx0) & (pix.RGB_X <= lx1) &
                    (pix.RGB_Y >= ly0) & (pix.RGB_Y <= ly1);
    assign pass   = (state == CAPTURE) & pix.RGB_VALID & in_win;
    assign is_sop = (pix.RGB_X == lx0) & (pix.RGB_Y == ly0);
    assign is_eop = (pix.RGB_X == lx1) & (pix.RGB_Y == ly1);

    assign done_eop   = pass & is_eop;
    assign done_short = (state == CAPTURE) & fvf & ~done_eop;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = ARM;
            end
            ARM: begin
                if (stop)                      state_nx = IDLE;
                else if (!pix.CAMERA_FVAL)     state_nx = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (stop)                      state_nx = IDLE;
                else if (fvr) begin
                    if (roi_bad || skip_cnt != 4'd0) state_nx = SKIP;
                    else                             state_nx = CAPTURE;
                end
            end
            SKIP: begin
                if (fvf) state_nx = stop_any ? IDLE : WAIT_SOF;
            end
            CAPTURE: begin
                if (done_eop || done_short)
                    state_nx = (!cont_l || stop_any) ? IDLE : WAIT_SOF;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            stop_pend <= 1'b0;
        end else if (state_nx == IDLE) begin
            stop_pend <= 1'b0;
        end else if (stop && state != IDLE) begin
            stop_pend <= 1'b1;
        end
    end

    // Configuration is sampled only at an accepted frame start
    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            lx0    <= '0;
            lx1    <= '0;
            ly0    <= '0;
            ly1    <= '0;
            cont_l <= 1'b0;
        end else if (sof_take) begin
            lx0    <= cx0;
            lx1    <= cx1;
            ly0    <= cy0;
            ly1    <= cy1;
            cont_l <= continuous;
        end
    end

    // An invalid ROI drops the frame without consuming a decimation slot
    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            skip_cnt <= '0;
        end else if (sof_take && !roi_bad) begin
            if (skip_cnt != 4'd0) skip_cnt <= skip_cnt - 4'd1;
            else                  skip_cnt <= skip;
        end
    end

    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            pix.OUT_R     <= '0;
            pix.OUT_G     <= '0;
            pix.OUT_B     <= '0;
            pix.OUT_VALID <= 1'b0;
            pix.OUT_SOP   <= 1'b0;
            pix.OUT_EOP   <= 1'b0;
        end else begin
            pix.OUT_R     <= pass ? pix.RGB_R : '0;
            pix.OUT_G     <= pass ? pix.RGB_G : '0;
            pix.OUT_B     <= pass ? pix.RGB_B : '0;
            pix.OUT_VALID <= pass;
            pix.OUT_SOP   <= pass & is_sop;
            pix.OUT_EOP   <= done_eop;
        end
    end

    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt   <= '0;
            short_frame <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (done_eop) frame_cnt <= frame_cnt + 1'b1;
            short_frame <= done_short;
            cfg_err     <= sof_take & roi_bad;
        end
    end

    assign busy = (state != IDLE);

endmodule
